// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake, control and counter bundle for one pipeline-stage register.
// Latency: none; this interface only carries wires between the stage and its neighbours.
// Backpressure: in_ready/out_ready are carried as-is; the stage decides when in_ready falls.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             freeze;
  logic             flush;
  logic             clr_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Master drives the payload and control; it sits on the upstream/controller side.
  modport master (
    output in_valid, in_data, out_ready, freeze, flush, clr_cnt,
    input  in_ready, out_valid, out_data, stall_cnt, flush_cnt
  );

  // Slave is the stage register itself.
  modport slave (
    input  in_valid, in_data, out_ready, freeze, flush, clr_cnt,
    output in_ready, out_valid, out_data, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with hazard freeze, branch flush and saturating stall/flush counters.
// Latency: one cycle from input transfer to out_valid; one item per cycle while out_ready is held high.
// Backpressure: with PIPE_SKID_EN a skid entry gives capacity 2 and in_ready has no path from out_ready;
//   without it, capacity 1 and in_ready = ~freeze & (~m_valid | out_ready).
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Main entry: the item currently presented downstream.
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;

  // Counters.
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Handshake qualifiers.
  logic in_xfer;
  logic out_xfer;
  logic skid_occ;
  logic stall_inc;
  logic flush_inc;

  assign bus.out_valid = m_valid_q & ~bus.freeze;
  assign bus.out_data  = m_data_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = bus.out_valid & bus.out_ready;

`ifdef PIPE_SKID_EN
  // Skid entry: catches the item accepted while main is stalled, so in_ready only depends on local state.
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;

  assign skid_occ     = s_valid_q;
  assign bus.in_ready = ~s_valid_q & ~bus.freeze;

  // Next-state for main and skid: flush empties both, freeze holds, otherwise advance in FIFO order.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (bus.flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!bus.freeze) begin
      if (out_xfer) begin
        if (s_valid_q) begin
          // Older skid item moves up; in_ready was low so no new item arrives this cycle.
          m_valid_d = 1'b1;
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else begin
          m_valid_d = 1'b0;
        end
      end
      if (in_xfer) begin
        if (!m_valid_q || out_xfer) begin
          // Main is empty or draining with an empty skid: the new item lands directly in main.
          m_valid_d = 1'b1;
          m_data_d  = bus.in_data;
        end else begin
          s_valid_d = 1'b1;
          s_data_d  = bus.in_data;
        end
      end
    end
  end

  // Skid register; reset drops the entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end
`else
  assign skid_occ     = 1'b0;
  assign bus.in_ready = ~bus.freeze & (~m_valid_q | bus.out_ready);

  // Next-state for the single entry: a new item replaces a departing one in the same cycle.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (bus.flush) begin
      m_valid_d = 1'b0;
    end else if (!bus.freeze) begin
      if (in_xfer) begin
        m_valid_d = 1'b1;
        m_data_d  = bus.in_data;
      end else if (out_xfer) begin
        m_valid_d = 1'b0;
      end
    end
  end
`endif

  // Stall counts freeze cycles and cycles where a held item is refused; flush counts only flushes that drop something.
  assign stall_inc = bus.freeze | (m_valid_q & ~bus.out_ready);
  assign flush_inc = bus.flush & (m_valid_q | skid_occ);

  // Saturating counter update; clear beats a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Main entry and counter registers; reset clears everything without waiting for an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scenarios plus randomized traffic against a queue-based reference model.
// Latency: the model exposes the head of its queue one cycle after acceptance, matching the stage.
// Backpressure: acceptance follows capacity (2 with PIPE_SKID_EN, otherwise 1 with pass-through on out_ready).
module tb_pipe_stage_reg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic rst;

  pipe_stage_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of held items plus two saturating counts.
  logic [WIDTH-1:0] mq[$];
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic exp_in_ready();
`ifdef PIPE_SKID_EN
    return !bus.freeze && (mq.size() < CAP);
`else
    return !bus.freeze && ((mq.size() == 0) || bus.out_ready);
`endif
  endfunction

  function automatic logic exp_out_valid();
    return (mq.size() > 0) && !bus.freeze;
  endfunction

  // Advance model by one cycle using the current inputs, then let the clock edge pass.
  task automatic tick();
    logic occ, oxf, ixf, st, fl;
    logic [WIDTH-1:0] d;
    occ = (mq.size() > 0);
    oxf = exp_out_valid() && bus.out_ready;
    ixf = bus.in_valid && exp_in_ready();
    d   = bus.in_data;
    st  = bus.freeze || (occ && !bus.out_ready);
    fl  = bus.flush && occ;
    if (bus.clr_cnt) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (st && m_stall < CMAX) m_stall++;
      if (fl && m_flush < CMAX) m_flush++;
    end
    if (bus.flush) begin
      mq.delete();
    end else if (!bus.freeze) begin
      if (oxf) void'(mq.pop_front());
      if (ixf) mq.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.freeze    = 1'b0;
    bus.flush     = 1'b0;
    bus.clr_cnt   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data got %0h exp 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Fill the stage with downstream stalled, then reset mid-cycle.
    for (int i = 0; i < CAP + 1; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(16'h0100 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h0100) begin errors++; $display("FAIL fill_head got %0b/%0h exp 1/0100", bus.out_valid, bus.out_data); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL async_rst_out_data got %0h exp 0", bus.out_data); end
    mq.delete();
    m_stall = 0;
    m_flush = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0b exp 1", bus.in_ready); end
    checks++; if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin errors++; $display("FAIL post_rst_cnt got %0d/%0d exp 0/0", bus.stall_cnt, bus.flush_cnt); end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] items [4];
    items[0] = 16'h0011; items[1] = 16'h0022; items[2] = 16'h0033; items[3] = 16'h0044;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = (k < 4);
      bus.in_data  = (k < 4) ? items[k] : '0;
      #1;
      if (k < 4) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b exp 1", k, bus.in_ready); end
      end
      if (k > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== items[k-1]) begin
          errors++; $display("FAIL stream_out[%0d] got %0b/%0h exp 1/%0h", k, bus.out_valid, bus.out_data, items[k-1]);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %0b exp 0", bus.out_valid); end
    checks++; if (bus.stall_cnt !== '0) begin errors++; $display("FAIL stream_stall_cnt got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] items [3];
    logic [WIDTH-1:0] rx[$];
    int idx;
    int cyc;
    items[0] = 16'h00A1; items[1] = 16'h00B2; items[2] = 16'h00C3;
    idx = 0;
    cyc = 0;
    while (!(idx == 3 && mq.size() == 0) && cyc < 40) begin
      bus.out_ready = (cyc >= 3);
      bus.in_valid  = (idx < 3);
      bus.in_data   = (idx < 3) ? items[idx] : '0;
      #1;
      checks++; if (bus.in_ready !== exp_in_ready()) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b exp %0b", cyc, bus.in_ready, exp_in_ready()); end
      checks++; if (bus.out_valid !== exp_out_valid()) begin errors++; $display("FAIL bp_out_valid[%0d] got %0b exp %0b", cyc, bus.out_valid, exp_out_valid()); end
      if (cyc == 2) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got %0b exp 0", bus.in_ready); end
      end
      if (exp_out_valid() && bus.out_ready) rx.push_back(bus.out_data);
      if (bus.in_valid && exp_in_ready()) idx++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (cyc >= 40) begin errors++; $display("FAIL bp_timeout got %0d cycles exp <40", cyc); end
    checks++; if (rx.size() != 3) begin errors++; $display("FAIL bp_rx_count got %0d exp 3", rx.size()); end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      checks++; if (rx[i] !== items[i]) begin errors++; $display("FAIL bp_order[%0d] got %0h exp %0h", i, rx[i], items[i]); end
    end
    #1;
    checks++; if (bus.stall_cnt !== m_stall[CNT_W-1:0]) begin errors++; $display("FAIL bp_stall_cnt got %0d exp %0d", bus.stall_cnt, m_stall); end
  endtask

  task automatic test_flush();
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt   = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(16'h0200 + i);
      tick();
    end
    bus.in_data = 16'h0077;
    bus.flush   = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %0b exp 0", bus.out_valid); end
    checks++; if (bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL flush_cnt_first got %0d exp 1", bus.flush_cnt); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_input_dropped got %0b exp 0", bus.out_valid); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.flush_cnt !== 4'd1) begin errors++; $display("FAIL flush_cnt_empty got %0d exp 1", bus.flush_cnt); end
  endtask

  task automatic test_freeze();
    bus.clr_cnt   = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h005A;
    bus.out_ready = 1'b0;
    tick();
    bus.clr_cnt   = 1'b0;
    bus.in_data   = 16'h0099;
    bus.freeze    = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL frz_out_valid[%0d] got %0b exp 0", k, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL frz_in_ready[%0d] got %0b exp 0", k, bus.in_ready); end
      tick();
    end
    bus.freeze    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h005A) begin errors++; $display("FAIL frz_resume got %0b/%0h exp 1/005a", bus.out_valid, bus.out_data); end
    checks++; if (bus.stall_cnt !== 4'd2) begin errors++; $display("FAIL frz_stall_cnt got %0d exp 2", bus.stall_cnt); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    bus.freeze  = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    #1;
    checks++; if (bus.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_stall_cnt got %0d exp 15", bus.stall_cnt); end
    bus.clr_cnt = 1'b1;
    tick();
    bus.clr_cnt = 1'b0;
    bus.freeze  = 1'b0;
    #1;
    checks++; if (bus.stall_cnt !== 4'd0) begin errors++; $display("FAIL sat_clr_wins got %0d exp 0", bus.stall_cnt); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.in_valid  = $urandom_range(0, 1);
      bus.in_data   = WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.freeze    = ($urandom_range(0, 9) == 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.clr_cnt   = ($urandom_range(0, 31) == 0);
      #1;
      checks++; if (bus.out_valid !== exp_out_valid()) begin errors++; $display("FAIL rnd_out_valid[%0d] got %0b exp %0b", k, bus.out_valid, exp_out_valid()); end
      checks++; if (bus.in_ready !== exp_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d] got %0b exp %0b", k, bus.in_ready, exp_in_ready()); end
      if (mq.size() > 0) begin
        checks++; if (bus.out_data !== mq[0]) begin errors++; $display("FAIL rnd_out_data[%0d] got %0h exp %0h", k, bus.out_data, mq[0]); end
      end
      checks++; if (bus.stall_cnt !== m_stall[CNT_W-1:0]) begin errors++; $display("FAIL rnd_stall_cnt[%0d] got %0d exp %0d", k, bus.stall_cnt, m_stall); end
      checks++; if (bus.flush_cnt !== m_flush[CNT_W-1:0]) begin errors++; $display("FAIL rnd_flush_cnt[%0d] got %0d exp %0d", k, bus.flush_cnt, m_flush); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_freeze();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
